tcp_conn_ctrl: RTL and testbench

Single-connection TCP receive-side controller sitting behind tcp_handler. Consumes its per-segment metadata, runs a passive-open connection FSM, decides accept/drop for each segment's forwarded payload, and issues transmit-control requests (SYN|ACK, ACK, FIN|ACK) to the TX builder. Owns rcv_nxt/snd_nxt sequence state.

---
 rtl/tcp_conn_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_tcp_conn_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_conn_ctrl.sv
// Receive-side TCP connection controller: passive-open FSM, per-segment accept/drop, control-segment tx requests.
// Optional idle abort in SYN_RCVD/LAST_ACK is built when TCP_CTRL_TIMEOUT_EN is defined.
//
// conn state  | meaning
// LISTEN      | waiting for a SYN on cfg_local_port
// SYN_RCVD    | SYN|ACK sent, waiting for the final handshake ACK
// ESTABLISHED | in-order payload accepted and acknowledged
// LAST_ACK    | FIN|ACK sent, waiting for the peer's ACK of our FIN
//
// ctl state   | meaning
// IDLE        | wait for valid, checksum-resolved metadata (and a free tx slot if needed)
// EVAL        | consume pulse with accept/drop; commit state, sequence numbers and tx request
// GUARD       | dead cycle while the producer retires the consumed metadata
module tcp_conn_ctrl #(
  parameter logic [15:0] RX_WINDOW = 16'hFFFF
`ifdef TCP_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cfg_local_port,
  input  logic [31:0] i_cfg_isn,
  input  logic        i_meta_valid,
  output logic        o_meta_ready,
  input  logic [15:0] i_meta_src_port,
  input  logic [15:0] i_meta_dst_port,
  input  logic [31:0] i_meta_seq_num,
  input  logic [31:0] i_meta_ack_num,
  input  logic [7:0]  i_meta_flags,
  input  logic [15:0] i_meta_payload_len,
  input  logic        i_meta_checksum_valid,
  input  logic        i_meta_checksum_ok,
  output logic        o_pkt_accept,
  output logic        o_pkt_drop,
  output logic        o_tx_req_valid,
  input  logic        i_tx_req_ready,
  output logic [15:0] o_tx_src_port,
  output logic [15:0] o_tx_dst_port,
  output logic [31:0] o_tx_seq,
  output logic [31:0] o_tx_ack,
  output logic [7:0]  o_tx_flags,
  output logic [15:0] o_tx_window,
  output logic [2:0]  o_conn_state,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_EVAL  = 2'd1,
    CTL_GUARD = 2'd2
  } ctl_t;

  typedef enum logic [2:0] {
    ST_LISTEN   = 3'd0,
    ST_SYN_RCVD = 3'd1,
    ST_ESTAB    = 3'd2,
    ST_LAST_ACK = 3'd3
  } conn_t;

  localparam logic [7:0] FL_ACK     = 8'h10;
  localparam logic [7:0] FL_SYN_ACK = 8'h12;
  localparam logic [7:0] FL_FIN_ACK = 8'h11;

  ctl_t        r_ctl;
  conn_t       r_conn;
  logic [31:0] r_rcv_nxt;
  logic [31:0] r_snd_nxt;
  logic [15:0] r_remote_port;
  logic [15:0] r_drop_cnt;
  logic        r_meta_ready;
  logic        r_pkt_accept;
  logic        r_pkt_drop;
  logic        r_tx_req_valid;
  logic [15:0] r_tx_src_port;
  logic [15:0] r_tx_dst_port;
  logic [31:0] r_tx_seq;
  logic [31:0] r_tx_ack;
  logic [7:0]  r_tx_flags;
  logic [15:0] r_tx_window;

  logic        w_fin;
  logic        w_syn;
  logic        w_rst_flag;
  logic        w_ack_flag;
  logic [31:0] w_rcv_adv;
  logic        w_accept;
  logic        w_count;
  logic        w_data;
  conn_t       w_conn_n;
  logic [31:0] w_rcv_n;
  logic [31:0] w_snd_n;
  logic [15:0] w_remote_n;
  logic        w_tx_load;
  logic [7:0]  w_tx_flags;
  logic [31:0] w_tx_seq;
  logic [31:0] w_tx_ack;
  logic        w_start;
  logic        w_unused;

  assign w_fin      = i_meta_flags[0];
  assign w_syn      = i_meta_flags[1];
  assign w_rst_flag = i_meta_flags[2];
  assign w_ack_flag = i_meta_flags[4];
  assign w_unused   = ^{i_meta_flags[7:5], i_meta_flags[3]};

  // FIN occupies one sequence number on top of the payload.
  assign w_rcv_adv = r_rcv_nxt + {16'd0, i_meta_payload_len} + {31'd0, w_fin};

  // Decision for the segment currently presented; inputs are held until the consume pulse.
  always_comb begin
    w_accept   = 1'b0;
    w_count    = 1'b0;
    w_data     = 1'b0;
    w_conn_n   = r_conn;
    w_rcv_n    = r_rcv_nxt;
    w_snd_n    = r_snd_nxt;
    w_remote_n = r_remote_port;
    w_tx_load  = 1'b0;
    w_tx_flags = 8'h00;
    w_tx_seq   = 32'd0;
    w_tx_ack   = 32'd0;
    if (!i_meta_checksum_ok || (i_meta_dst_port != i_cfg_local_port) ||
        ((r_conn != ST_LISTEN) && (i_meta_src_port != r_remote_port))) begin
      w_count = 1'b1;
    end else if (w_rst_flag) begin
      if (r_conn == ST_LISTEN) w_count  = 1'b1;
      else                     w_conn_n = ST_LISTEN;
    end else begin
      case (r_conn)
        ST_LISTEN: begin
          if (w_syn && !w_ack_flag) begin
            w_remote_n = i_meta_src_port;
            w_rcv_n    = i_meta_seq_num + 32'd1;
            w_snd_n    = i_cfg_isn + 32'd1;
            w_tx_load  = 1'b1;
            w_tx_flags = FL_SYN_ACK;
            w_tx_seq   = i_cfg_isn;
            w_tx_ack   = i_meta_seq_num + 32'd1;
            w_conn_n   = ST_SYN_RCVD;
          end else begin
            w_count = 1'b1;
          end
        end
        ST_SYN_RCVD: begin
          if (w_ack_flag && (i_meta_ack_num == r_snd_nxt)) w_data  = 1'b1;
          else                                             w_count = 1'b1;
        end
        ST_ESTAB: w_data = 1'b1;
        ST_LAST_ACK: begin
          if (w_ack_flag && (i_meta_ack_num == r_snd_nxt)) w_conn_n = ST_LISTEN;
          else                                             w_count  = 1'b1;
        end
        default: w_count = 1'b1;
      endcase
      // Data rule, also reached by the handshake-completing ACK.
      if (w_data) begin
        w_conn_n = ST_ESTAB;
        w_tx_seq = r_snd_nxt;
        if (i_meta_seq_num == r_rcv_nxt) begin
          w_accept = 1'b1;
          w_rcv_n  = w_rcv_adv;
          w_tx_ack = w_rcv_adv;
          if (w_fin) begin
            w_tx_load  = 1'b1;
            w_tx_flags = FL_FIN_ACK;
            w_snd_n    = r_snd_nxt + 32'd1;
            w_conn_n   = ST_LAST_ACK;
          end else if (i_meta_payload_len != 16'd0) begin
            w_tx_load  = 1'b1;
            w_tx_flags = FL_ACK;
          end
        end else begin
          w_count    = 1'b1;
          w_tx_load  = 1'b1;
          w_tx_flags = FL_ACK;
          w_tx_ack   = r_rcv_nxt;
        end
      end
    end
  end

  assign w_start = i_meta_valid && i_meta_checksum_valid && !(w_tx_load && r_tx_req_valid);

`ifdef TCP_CTRL_TIMEOUT_EN
  localparam logic [31:0] TO_LOAD = 32'(TIMEOUT_CYCLES);
  logic [31:0] r_to_cnt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctl          <= CTL_IDLE;
      r_conn         <= ST_LISTEN;
      r_rcv_nxt      <= 32'd0;
      r_snd_nxt      <= 32'd0;
      r_remote_port  <= 16'd0;
      r_drop_cnt     <= 16'd0;
      r_meta_ready   <= 1'b0;
      r_pkt_accept   <= 1'b0;
      r_pkt_drop     <= 1'b0;
      r_tx_req_valid <= 1'b0;
      r_tx_src_port  <= 16'd0;
      r_tx_dst_port  <= 16'd0;
      r_tx_seq       <= 32'd0;
      r_tx_ack       <= 32'd0;
      r_tx_flags     <= 8'h00;
      r_tx_window    <= 16'd0;
`ifdef TCP_CTRL_TIMEOUT_EN
      r_to_cnt       <= TO_LOAD;
`endif
    end else begin
      r_meta_ready <= 1'b0;
      r_pkt_accept <= 1'b0;
      r_pkt_drop   <= 1'b0;
      if (r_tx_req_valid && i_tx_req_ready) r_tx_req_valid <= 1'b0;
      case (r_ctl)
        CTL_IDLE: begin
          if (w_start) begin
            r_ctl        <= CTL_EVAL;
            r_meta_ready <= 1'b1;
            r_pkt_accept <= w_accept;
            r_pkt_drop   <= !w_accept;
          end
        end
        CTL_EVAL: begin
          r_ctl         <= CTL_GUARD;
          r_conn        <= w_conn_n;
          r_rcv_nxt     <= w_rcv_n;
          r_snd_nxt     <= w_snd_n;
          r_remote_port <= w_remote_n;
          if (w_count && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
          if (w_tx_load) begin
            r_tx_req_valid <= 1'b1;
            r_tx_src_port  <= i_cfg_local_port;
            r_tx_dst_port  <= w_remote_n;
            r_tx_seq       <= w_tx_seq;
            r_tx_ack       <= w_tx_ack;
            r_tx_flags     <= w_tx_flags;
            r_tx_window    <= RX_WINDOW;
          end
        end
        CTL_GUARD: r_ctl <= CTL_IDLE;
        default:   r_ctl <= CTL_IDLE;
      endcase
`ifdef TCP_CTRL_TIMEOUT_EN
      // Down-counter only runs while half-open/half-closed and no segment is in flight.
      if ((r_ctl == CTL_EVAL) || (r_conn == ST_LISTEN) || (r_conn == ST_ESTAB)) begin
        r_to_cnt <= TO_LOAD;
      end else if ((r_ctl == CTL_IDLE) && !w_start) begin
        if (r_to_cnt <= 32'd1) begin
          r_conn   <= ST_LISTEN;
          r_to_cnt <= TO_LOAD;
        end else begin
          r_to_cnt <= r_to_cnt - 32'd1;
        end
      end
`endif
    end
  end

  assign o_meta_ready   = r_meta_ready;
  assign o_pkt_accept   = r_pkt_accept;
  assign o_pkt_drop     = r_pkt_drop;
  assign o_tx_req_valid = r_tx_req_valid;
  assign o_tx_src_port  = r_tx_src_port;
  assign o_tx_dst_port  = r_tx_dst_port;
  assign o_tx_seq       = r_tx_seq;
  assign o_tx_ack       = r_tx_ack;
  assign o_tx_flags     = r_tx_flags;
  assign o_tx_window    = r_tx_window;
  assign o_conn_state   = r_conn;
  assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_tcp_conn_ctrl.sv
// Bench for tcp_conn_ctrl: directed handshake/data/close/filter/backpressure/wrap/reset cases, then random segments
// checked against a rule-level connection model.
module tb_tcp_conn_ctrl;

  localparam logic [15:0] LPORT = 16'd80;
  localparam int M_LISTEN = 0;
  localparam int M_SYN    = 1;
  localparam int M_EST    = 2;
  localparam int M_LAST   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] isn = 32'h0000_A000;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic [15:0] meta_src = 16'd0;
  logic [15:0] meta_dst = 16'd0;
  logic [31:0] meta_seq = 32'd0;
  logic [31:0] meta_ack = 32'd0;
  logic [7:0]  meta_flags = 8'd0;
  logic [15:0] meta_len = 16'd0;
  logic        ck_valid = 1'b0;
  logic        ck_ok = 1'b0;
  logic        pkt_accept, pkt_drop;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] tx_src, tx_dst, tx_window, drop_cnt;
  logic [31:0] tx_seq, tx_ack;
  logic [7:0]  tx_flags;
  logic [2:0]  conn_state;

  int n_checks = 0;
  int n_err    = 0;

  int          m_state  = M_LISTEN;
  logic [31:0] m_rcv    = 32'd0;
  logic [31:0] m_snd    = 32'd0;
  logic [15:0] m_remote = 16'd0;
  int          m_drops  = 0;
  logic [31:0] last_tx_ack = 32'd0;

  always #5 clk = ~clk;

  tcp_conn_ctrl #(
    .RX_WINDOW(16'hFFFF)
`ifdef TCP_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_local_port(LPORT), .i_cfg_isn(isn),
    .i_meta_valid(meta_valid), .o_meta_ready(meta_ready),
    .i_meta_src_port(meta_src), .i_meta_dst_port(meta_dst),
    .i_meta_seq_num(meta_seq), .i_meta_ack_num(meta_ack), .i_meta_flags(meta_flags),
    .i_meta_payload_len(meta_len), .i_meta_checksum_valid(ck_valid), .i_meta_checksum_ok(ck_ok),
    .o_pkt_accept(pkt_accept), .o_pkt_drop(pkt_drop),
    .o_tx_req_valid(tx_valid), .i_tx_req_ready(tx_ready),
    .o_tx_src_port(tx_src), .o_tx_dst_port(tx_dst), .o_tx_seq(tx_seq), .o_tx_ack(tx_ack),
    .o_tx_flags(tx_flags), .o_tx_window(tx_window), .o_conn_state(conn_state), .o_drop_cnt(drop_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] add32(input longint unsigned a, input longint unsigned b);
    longint unsigned s;
    s = (a + b) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  // Connection rules applied to one consumed segment; updates the model's connection record.
  task automatic model_seg(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] seq,
                           input logic [31:0] ack, input logic [7:0] fl, input logic [15:0] len,
                           input bit ok, output bit acc, output bit tx, output logic [7:0] tf,
                           output logic [31:0] ts, output logic [31:0] ta);
    bit fin, syn, rs, ak, count, data;
    fin = fl[0]; syn = fl[1]; rs = fl[2]; ak = fl[4];
    count = 0; data = 0;
    acc = 0; tx = 0; tf = 8'h00; ts = 32'd0; ta = 32'd0;
    if (!ok || dst != LPORT || (m_state != M_LISTEN && src != m_remote)) count = 1;
    else if (rs) begin
      if (m_state == M_LISTEN) count = 1;
      else m_state = M_LISTEN;
    end else if (m_state == M_LISTEN) begin
      if (syn && !ak) begin
        m_remote = src;
        m_rcv    = add32(seq, 1);
        m_snd    = add32(isn, 1);
        tx = 1; tf = 8'h12; ts = isn; ta = m_rcv;
        m_state  = M_SYN;
      end else count = 1;
    end else if (m_state == M_SYN) begin
      if (ak && ack == m_snd) data = 1;
      else count = 1;
    end else if (m_state == M_EST) data = 1;
    else begin
      if (ak && ack == m_snd) m_state = M_LISTEN;
      else count = 1;
    end
    if (data) begin
      m_state = M_EST;
      if (seq == m_rcv) begin
        acc   = 1;
        m_rcv = add32(m_rcv, longint'(len) + (fin ? 1 : 0));
        if (fin) begin
          tx = 1; tf = 8'h11; ts = m_snd; ta = m_rcv;
          m_snd   = add32(m_snd, 1);
          m_state = M_LAST;
        end else if (len > 0) begin
          tx = 1; tf = 8'h10; ts = m_snd; ta = m_rcv;
        end
      end else begin
        count = 1;
        tx = 1; tf = 8'h10; ts = m_snd; ta = m_rcv;
      end
    end
    if (count && m_drops < 65535) m_drops++;
  endtask

  task automatic send_seg(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] seq,
                          input logic [31:0] ack, input logic [7:0] fl, input logic [15:0] len,
                          input bit ok, input int stall);
    bit exp_acc, exp_tx, got, seen;
    logic [7:0]  ef, c_flags;
    logic [31:0] es, ea, c_seq, c_ack;
    logic [15:0] c_src, c_dst, c_win;
    int n;
    model_seg(src, dst, seq, ack, fl, len, ok, exp_acc, exp_tx, ef, es, ea);
    @(posedge clk); #1;
    meta_src = src; meta_dst = dst; meta_seq = seq; meta_ack = ack;
    meta_flags = fl; meta_len = len; ck_ok = ok; ck_valid = 1'b1; meta_valid = 1'b1;
    if (stall > 0) begin
      n = 0;
      repeat (stall) begin
        @(negedge clk);
        if (meta_ready) n++;
      end
      check_val("stall_no_consume", 32'(n), 32'd0);
      check_val("stall_tx_held", 32'(tx_valid), 32'd1);
      tx_ready = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (meta_ready) got = 1;
    end
    check_val("consume", 32'(got), 32'd1);
    check_val("accept", 32'(pkt_accept), 32'(exp_acc));
    check_val("drop", 32'(pkt_drop), 32'(!exp_acc));
    @(posedge clk); #1;
    meta_valid = 1'b0; ck_valid = 1'b0;
    meta_src = 16'($urandom); meta_dst = LPORT; meta_seq = $urandom; meta_flags = 8'($urandom);
    seen = 0;
    c_flags = 0; c_seq = 0; c_ack = 0; c_src = 0; c_dst = 0; c_win = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid && !seen) begin
        seen = 1;
        c_flags = tx_flags; c_seq = tx_seq; c_ack = tx_ack;
        c_src = tx_src; c_dst = tx_dst; c_win = tx_window;
      end
    end
    check_val("tx_req", 32'(seen), 32'(exp_tx));
    if (seen && exp_tx) begin
      last_tx_ack = c_ack;
      check_val("tx_flags", 32'(c_flags), 32'(ef));
      check_val("tx_seq", c_seq, es);
      check_val("tx_ack", c_ack, ea);
      check_val("tx_src", 32'(c_src), 32'(LPORT));
      check_val("tx_dst", 32'(c_dst), 32'(m_remote));
      check_val("tx_window", 32'(c_win), 32'hFFFF);
    end
    check_val("state", 32'(conn_state), 32'(m_state));
    check_val("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    bit seen, got;
    logic [15:0] src, dst, len;
    logic [31:0] seq, ack;
    logic [7:0]  fl;
    bit ok;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_meta_ready", 32'(meta_ready), 32'd0);
    check_val("rst_accept", 32'(pkt_accept), 32'd0);
    check_val("rst_drop", 32'(pkt_drop), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_tx_ack", tx_ack, 32'd0);
    check_val("rst_state", 32'(conn_state), 32'd0);
    check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Handshake, data, duplicate ACK, close
    isn = 32'h0000_A000;
    send_seg(16'd1234, LPORT, 32'h1000, 32'h0, 8'h02, 16'd0, 1, 0);
    send_seg(16'd1234, LPORT, 32'h1001, 32'hA001, 8'h10, 16'd0, 1, 0);
    send_seg(16'd1234, LPORT, 32'h1001, 32'hA001, 8'h18, 16'd100, 1, 0);
    check_val("plan_data_ack", last_tx_ack, 32'h1065);
    send_seg(16'd1234, LPORT, 32'h2000, 32'hA001, 8'h18, 16'd10, 1, 0);
    check_val("plan_dup_drops", 32'(drop_cnt), 32'd1);
    send_seg(16'd1234, LPORT, 32'h1065, 32'hA001, 8'h11, 16'd0, 1, 0);
    check_val("plan_fin_ack", last_tx_ack, 32'h1066);
    send_seg(16'd1234, LPORT, 32'h1066, 32'hA002, 8'h10, 16'd0, 1, 0);

    // Filters in LISTEN
    send_seg(16'd1234, LPORT, 32'h3000, 32'h0, 8'h02, 16'd0, 0, 0);
    send_seg(16'd1234, 16'd81, 32'h3000, 32'h0, 8'h02, 16'd0, 1, 0);
    send_seg(16'd1234, LPORT, 32'h3000, 32'h0, 8'h04, 16'd0, 1, 0);
    check_val("plan_filter_drops", 32'(drop_cnt), 32'd4);

    // Backpressure on the tx slot
    isn = 32'h0000_7000;
    send_seg(16'd4000, LPORT, 32'h5000, 32'h0, 8'h02, 16'd0, 1, 0);
    send_seg(16'd4000, LPORT, 32'h5001, 32'h7001, 8'h10, 16'd0, 1, 0);
    tx_ready = 1'b0;
    send_seg(16'd4000, LPORT, 32'h5001, 32'h7001, 8'h18, 16'd4, 1, 0);
    send_seg(16'd4000, LPORT, 32'h5005, 32'h7001, 8'h18, 16'd8, 1, 10);

    // Sequence wrap on both directions
    send_seg(16'd4000, LPORT, 32'h500D, 32'h7001, 8'h04, 16'd0, 1, 0);
    isn = 32'hFFFF_FFFF;
    send_seg(16'd4001, LPORT, 32'hFFFF_FFEF, 32'h0, 8'h02, 16'd0, 1, 0);
    send_seg(16'd4001, LPORT, 32'hFFFF_FFF0, 32'h0, 8'h10, 16'd0, 1, 0);
    send_seg(16'd4001, LPORT, 32'hFFFF_FFF0, 32'h0, 8'h18, 16'd32, 1, 0);
    check_val("wrap_ack", last_tx_ack, 32'h10);

    // Reset while a drop-with-dup-ACK segment is in EVAL
    @(posedge clk); #1;
    meta_src = 16'd4001; meta_dst = LPORT; meta_seq = 32'h500; meta_ack = 32'h0;
    meta_flags = 8'h18; meta_len = 16'd4; ck_ok = 1'b1; ck_valid = 1'b1; meta_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (meta_ready) got = 1;
    end
    check_val("rst_eval_consume", 32'(got), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; meta_valid = 1'b0; ck_valid = 1'b0;
    m_state = M_LISTEN; m_rcv = 0; m_snd = 0; m_remote = 0; m_drops = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    check_val("rst_eval_no_tx", 32'(seen), 32'd0);
    check_val("rst_eval_state", 32'(conn_state), 32'd0);
    check_val("rst_eval_drop_cnt", 32'(drop_cnt), 32'd0);

`ifdef TCP_CTRL_TIMEOUT_EN
    isn = 32'h0000_1111;
    send_seg(16'd2222, LPORT, 32'h100, 32'h0, 8'h02, 16'd0, 1, 0);
    repeat (40) @(negedge clk);
    check_val("to_still_syn_rcvd", 32'(conn_state), 32'(M_SYN));
    repeat (20) @(negedge clk);
    m_state = M_LISTEN;
    check_val("to_listen", 32'(conn_state), 32'(M_LISTEN));
    check_val("to_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    check_val("to_no_tx", 32'(tx_valid), 32'd0);
`endif

    // Random segments
    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 11);
      if (m_state == M_LISTEN && $urandom_range(0, 1) == 1) kind = 3;
      src = m_remote; dst = LPORT; seq = m_rcv; ack = m_snd; fl = 8'h10; len = 16'd0; ok = 1;
      case (kind)
        0: begin ok = 0; len = 16'($urandom_range(0, 50)); fl = 8'h18; end
        1: dst = LPORT + 16'd1;
        2: fl = 8'h04;
        3: begin
          fl = 8'h02; src = 16'($urandom_range(1024, 65535)); seq = $urandom;
          if (m_state == M_LISTEN) isn = $urandom;
        end
        4: fl = 8'h10;
        5, 6: begin fl = 8'h18; len = 16'($urandom_range(1, 300)); end
        7: begin seq = add32(m_rcv, $urandom_range(1, 1000)); fl = 8'h18; len = 16'($urandom_range(0, 64)); end
        8: begin fl = 8'h11; len = 16'($urandom_range(0, 20)); end
        9: begin src = m_remote + 16'd1; fl = 8'h18; len = 16'd5; end
        10: ack = add32(m_snd, $urandom_range(1, 5));
        default: fl = 8'h12;
      endcase
      send_seg(src, dst, seq, ack, fl, len, ok, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
